// File: rtl/tt_check_pkg.sv
// -----------------------------------------------------------------------------
// tt_check_pkg
// Shared definitions for the truth-table response checker:
//   - FSM state encodings (IDLE, SETTLE, SAMPLE, DONE) as plain constants plus
//     an enum view of the same encodings for debug/readability
//   - SETTLE_W : width of the settle down-counter (holds SETTLE-1, SETTLE <= 15)
//   - tt_depth(): number of input vectors for a given input count
// No ports (package).
// -----------------------------------------------------------------------------
package tt_check_pkg;

  localparam int SETTLE_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_SAMPLE = ST_SAMPLE,
    S_DONE   = ST_DONE
  } tt_state_e;

  // Number of vectors in an exhaustive sweep of n_in inputs.
  function automatic int tt_depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// -----------------------------------------------------------------------------
// tt_settle_timer
// Loadable down-counter with a zero flag. Used to hold each vector on the DUT
// for a fixed number of cycles before it is sampled.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (counter -> 0)
//   load_i     in   load load_val_i (has priority over dec_i)
//   load_val_i in   value to load
//   dec_i      in   decrement by one (saturates at zero)
//   zero_o     out  counter is zero
// -----------------------------------------------------------------------------
module tt_settle_timer
  import tt_check_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_response_checker.sv
// -----------------------------------------------------------------------------
// tt_response_checker
// Exhaustive truth-table sweep of a small combinational DUT. Each input vector
// is driven on dut_in, held for SETTLE cycles, then dut_out is sampled for one
// cycle and compared with EXPECTED[vector]. After the last vector the captured
// table, error count and first failing vector are frozen and done is raised.
//
// Parameters:
//   N_IN     DUT input count (1..4); DEPTH = 2**N_IN vectors
//   SETTLE   cycles each vector is held before sampling (1..15)
//   EXPECTED expected table, bit i = expected output for vector i
//
// Build option:
//   TT_CHECK_STOP_ON_ERR_EN  when defined, the first mismatching sample ends
//                            the sweep immediately (dut_in frozen there).
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   synchronous active-high reset, wins over everything
//   start           in   begin sweep; honoured only in IDLE or DONE
//   dut_in          out  vector applied to the DUT (A = MSB)
//   dut_out         in   DUT response
//   busy            out  high in SETTLE/SAMPLE
//   done            out  high in DONE until next start or reset
//   pass            out  valid while done; 1 iff no mismatch
//   captured        out  captured table, bit i = sampled dut_out for vector i
//   err_count       out  number of mismatching vectors
//   first_err       out  index of first mismatch
//   first_err_valid out  at least one mismatch recorded
// -----------------------------------------------------------------------------
module tt_response_checker
  import tt_check_pkg::*;
#(
  parameter int                          N_IN     = 3,
  parameter int                          SETTLE   = 1,
  parameter logic [tt_depth(N_IN)-1:0]   EXPECTED = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [tt_depth(N_IN)-1:0] captured,
  output logic [N_IN:0]             err_count,
  output logic [N_IN-1:0]           first_err,
  output logic                      first_err_valid
);

  localparam int                  DEPTH       = tt_depth(N_IN);
  localparam logic [N_IN-1:0]     LAST_IDX    = N_IN'(DEPTH - 1);
  // SETTLE cycles in SETTLE state: counter starts at SETTLE-1 and the state
  // is left on the cycle it reads zero.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  logic [1:0]       state_q,    state_d;
  logic [N_IN-1:0]  idx_q,      idx_d;
  logic             pass_q,     pass_d;
  logic [DEPTH-1:0] captured_q, captured_d;
  logic [N_IN:0]    err_q,      err_d;
  logic [N_IN-1:0]  first_err_q, first_err_d;
  logic             fev_q,      fev_d;

  logic timer_load;
  logic timer_dec;
  logic timer_zero;
  logic mism;

  tt_settle_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    captured_d  = captured_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    fev_d       = fev_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    mism        = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_SETTLE;
          idx_d       = '0;
          captured_d  = '0;
          err_d       = '0;
          first_err_d = '0;
          fev_d       = 1'b0;
          pass_d      = 1'b0;
          timer_load  = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (timer_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end

      ST_SAMPLE: begin
        mism              = (dut_out != EXPECTED[idx_q]);
        captured_d[idx_q] = dut_out;
        if (mism) begin
          err_d = err_q + (N_IN + 1)'(1);
          if (!fev_q) begin
            first_err_d = idx_q;
            fev_d       = 1'b1;
          end
        end
`ifdef TT_CHECK_STOP_ON_ERR_EN
        if (mism) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
        end else
`endif
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          // Includes the mismatch of this final sample, not yet in err_q.
          pass_d  = (err_q == '0) && !mism;
        end else begin
          // dut_in follows idx, so the next vector appears on this same edge.
          idx_d      = idx_q + N_IN'(1);
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pass_q      <= 1'b0;
      captured_q  <= '0;
      err_q       <= '0;
      first_err_q <= '0;
      fev_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      captured_q  <= captured_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      fev_q       <= fev_d;
    end
  end

  assign dut_in          = idx_q;
  assign busy            = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign captured        = captured_q;
  assign err_count       = err_q;
  assign first_err       = first_err_q;
  assign first_err_valid = fev_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// -----------------------------------------------------------------------------
// tb_tt_response_checker
// Two checker instances: a 3-input/SETTLE=1 one against a majority gate (or a
// stuck-at-0 output) and a 4-input/SETTLE=3 one against a 4-input parity gate.
// Expected sweep results come from a reference model pushed to a scoreboard
// when a sweep starts and popped when done is observed.
// -----------------------------------------------------------------------------
module tb_tt_response_checker;

  localparam logic [7:0]  EXP3 = 8'hE8;
  localparam logic [15:0] EXP4 = 16'h6996;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic start3 = 1'b0;
  logic start4 = 1'b0;
  logic stuck3 = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 3: N_IN=3, SETTLE=1
  logic [2:0] dut_in3;
  logic       dut_out3, busy3, done3, pass3, fev3;
  logic [7:0] cap3;
  logic [3:0] err3;
  logic [2:0] fe3;

  assign dut_out3 = stuck3 ? 1'b0 :
                    ((dut_in3[2] & dut_in3[1]) | (dut_in3[2] & dut_in3[0]) |
                     (dut_in3[1] & dut_in3[0]));

  tt_response_checker #(.N_IN(3), .SETTLE(1), .EXPECTED(EXP3)) u_dut3 (
    .clk             (clk),
    .reset           (reset),
    .start           (start3),
    .dut_in          (dut_in3),
    .dut_out         (dut_out3),
    .busy            (busy3),
    .done            (done3),
    .pass            (pass3),
    .captured        (cap3),
    .err_count       (err3),
    .first_err       (fe3),
    .first_err_valid (fev3)
  );

  // Instance 4: N_IN=4, SETTLE=3
  logic [3:0]  dut_in4;
  logic        dut_out4, busy4, done4, pass4, fev4;
  logic [15:0] cap4;
  logic [4:0]  err4;
  logic [3:0]  fe4;

  assign dut_out4 = ^dut_in4;

  tt_response_checker #(.N_IN(4), .SETTLE(3), .EXPECTED(EXP4)) u_dut4 (
    .clk             (clk),
    .reset           (reset),
    .start           (start4),
    .dut_in          (dut_in4),
    .dut_out         (dut_out4),
    .busy            (busy4),
    .done            (done4),
    .pass            (pass4),
    .captured        (cap4),
    .err_count       (err4),
    .first_err       (fe4),
    .first_err_valid (fev4)
  );

  typedef struct {
    logic [15:0] captured;
    int          err;
    int          fe;
    logic        fev;
    logic        pass;
    int          latency;
    int          last_in;
  } exp_t;

  exp_t sb3[$];
  exp_t sb4[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc3, acc4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Truth tables of the behavioural DUTs, derived from their definitions.
  function automatic logic [15:0] maj_tt();
    logic [15:0] t = '0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v = 3'(i);
      t[i] = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    end
    return t;
  endfunction

  function automatic logic [15:0] par_tt();
    logic [15:0] t = '0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v = 4'(i);
      t[i] = v[3] ^ v[2] ^ v[1] ^ v[0];
    end
    return t;
  endfunction

  // Reference sweep model.
  function automatic exp_t model(input logic [15:0] dut_tt, input logic [15:0] exp_tt,
                                 input int depth, input int settle);
    exp_t r;
    r.captured = '0;
    r.err      = 0;
    r.fe       = 0;
    r.fev      = 1'b0;
    r.latency  = depth * (settle + 1);
    r.last_in  = depth - 1;
    for (int i = 0; i < depth; i++) begin
      r.captured[i] = dut_tt[i];
      if (dut_tt[i] != exp_tt[i]) begin
        r.err++;
        if (!r.fev) begin
          r.fe  = i;
          r.fev = 1'b1;
        end
`ifdef TT_CHECK_STOP_ON_ERR_EN
        r.latency = (i + 1) * (settle + 1);
        r.last_in = i;
        break;
`endif
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic compare(input string tag, input exp_t e, input int lat,
                         input logic [31:0] cap, input logic [31:0] err,
                         input logic [31:0] fe, input logic fev, input logic ps,
                         input logic dn, input logic bsy, input logic [31:0] din);
    check({tag, ".latency"},   32'(lat),      32'(e.latency));
    check({tag, ".done"},      {31'd0, dn},   32'd1);
    check({tag, ".busy"},      {31'd0, bsy},  32'd0);
    check({tag, ".captured"},  cap,           {16'd0, e.captured});
    check({tag, ".err_count"}, err,           32'(e.err));
    check({tag, ".first_err"}, fe,            32'(e.fe));
    check({tag, ".fev"},       {31'd0, fev},  {31'd0, e.fev});
    check({tag, ".pass"},      {31'd0, ps},   {31'd0, e.pass});
    check({tag, ".dut_in"},    din,           32'(e.last_in));
  endtask

  task automatic start_sweep3();
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    acc3 = cyc;
    sb3.push_back(model(stuck3 ? 16'h0000 : maj_tt(), {8'h00, EXP3}, 8, 1));
  endtask

  task automatic finish_sweep3(input string tag);
    int   n = 0;
    exp_t e;
    while (!done3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".done_seen"}, {31'd0, done3}, 32'd1);
    check({tag, ".sb_size"}, 32'(sb3.size()), 32'd1);
    if (sb3.size() != 0) begin
      e = sb3.pop_front();
      compare(tag, e, cyc - acc3, {24'd0, cap3}, {28'd0, err3}, {29'd0, fe3},
              fev3, pass3, done3, busy3, {29'd0, dut_in3});
    end
  endtask

  task automatic check_zero3(input string tag);
    check({tag, ".dut_in"},    {29'd0, dut_in3}, 32'd0);
    check({tag, ".busy"},      {31'd0, busy3},   32'd0);
    check({tag, ".done"},      {31'd0, done3},   32'd0);
    check({tag, ".pass"},      {31'd0, pass3},   32'd0);
    check({tag, ".captured"},  {24'd0, cap3},    32'd0);
    check({tag, ".err_count"}, {28'd0, err3},    32'd0);
    check({tag, ".first_err"}, {29'd0, fe3},     32'd0);
    check({tag, ".fev"},       {31'd0, fev3},    32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic ok;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero3("rst3");
    check("rst4.done", {31'd0, done4}, 32'd0);
    check("rst4.dut_in", {28'd0, dut_in4}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: majority, full pass
    stuck3 = 1'b0;
    start_sweep3();
    finish_sweep3("t1");
    repeat (3) @(negedge clk);
    check("t1.done_held", {31'd0, done3}, 32'd1);
    check("t1.cap_held", {24'd0, cap3}, 32'h0000_00E8);

    // 2: stuck-at-0 DUT
    stuck3 = 1'b1;
    start_sweep3();
    finish_sweep3("t2");
    stuck3 = 1'b0;

    // 3: 4-input parity, SETTLE=3; each vector held for SETTLE+1 cycles
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    acc4 = cyc;
    sb4.push_back(model(par_tt(), EXP4, 16, 3));
    for (int v = 0; v < 16; v++) begin
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if ((dut_in4 !== 4'(v)) || (busy4 !== 1'b1)) ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("t3.hold_v%0d", v), {31'd0, ok}, 32'd1);
    end
    n = 0;
    while (!done4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t3.sb_size", 32'(sb4.size()), 32'd1);
    if (sb4.size() != 0) begin
      e = sb4.pop_front();
      compare("t3", e, cyc - acc4, {16'd0, cap4}, {27'd0, err4}, {28'd0, fe4},
              fev4, pass4, done4, busy4, {28'd0, dut_in4});
    end

    // 4: reset during vector 5 aborts the sweep
    start_sweep3();
    repeat (10) @(negedge clk);
    check("t4.at_vec5", {29'd0, dut_in3}, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero3("t4.after_rst");
    sb3.delete();
    repeat (5) @(negedge clk);
    check("t4.stay_idle", {30'd0, busy3, done3}, 32'd0);
    start_sweep3();
    finish_sweep3("t4.rerun");

    // 5: start while busy is ignored
    start_sweep3();
    repeat (4) @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("t5.busy_ignored", {29'd0, dut_in3}, 32'd2);
    finish_sweep3("t5");

    // 5b: start in DONE clears results and begins a new sweep
    stuck3 = 1'b1;
    start_sweep3();
    check("t5b.done_clr", {31'd0, done3}, 32'd0);
    check("t5b.busy", {31'd0, busy3}, 32'd1);
    check("t5b.cap_clr", {24'd0, cap3}, 32'd0);
    check("t5b.err_clr", {28'd0, err3}, 32'd0);
    check("t5b.pass_clr", {31'd0, pass3}, 32'd0);
    check("t5b.dut_in", {29'd0, dut_in3}, 32'd0);
    finish_sweep3("t5b");
    stuck3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
